// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates tags at issue, captures CDB results, retires at head.
// Optional feature macro ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_wb,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  qj_tag,
  output logic              qj_rdy,
  output logic [DATA_W-1:0] qj_data,
  input  logic [TAG_W-1:0]  qk_tag,
  output logic              qk_rdy,
  output logic [DATA_W-1:0] qk_data,
  output logic              commit_valid,
  output logic              commit_wen,
  output logic [REG_W-1:0]  commit_idx,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] FullCnt = (TAG_W+1)'(DEPTH);

  logic              busy_q [DEPTH];
  logic              done_q [DEPTH];
  logic              wb_q   [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q, count_d;
  logic             alloc_fire, cdb_fire, retire, flush_req;

`ifdef ROB_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign count     = count_q;
  assign alloc_tag = tail_q;

  always_comb begin
    // Full-ness comes from registered count only; a same-cycle retire does not open a slot.
    alloc_ready = (count_q != FullCnt);
    alloc_fire  = alloc_valid & alloc_ready;
    retire      = busy_q[head_q] & done_q[head_q];
    cdb_fire    = cdb_valid & busy_q[cdb_tag] & ~done_q[cdb_tag];
    count_d     = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
  end

  // Operand lookup with same-cycle CDB bypass.
  always_comb begin
    qj_rdy  = 1'b0;
    qj_data = '0;
    if (cdb_valid && cdb_tag == qj_tag) begin
      qj_rdy  = 1'b1;
      qj_data = cdb_data;
    end else if (busy_q[qj_tag]) begin
      qj_rdy  = done_q[qj_tag];
      qj_data = data_q[qj_tag];
    end
  end

  always_comb begin
    qk_rdy  = 1'b0;
    qk_data = '0;
    if (cdb_valid && cdb_tag == qk_tag) begin
      qk_rdy  = 1'b1;
      qk_data = cdb_data;
    end else if (busy_q[qk_tag]) begin
      qk_rdy  = done_q[qk_tag];
      qk_data = data_q[qk_tag];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      commit_wen   <= 1'b0;
      commit_idx   <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
    end else if (flush_req) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      commit_wen   <= 1'b0;
    end else begin
      commit_valid <= retire;
      commit_wen   <= retire & wb_q[head_q];
      if (retire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        commit_idx     <= rd_q[head_q];
        commit_data    <= data_q[head_q];
        commit_tag     <= head_q;
        head_q         <= head_q + TAG_W'(1);
      end
      if (cdb_fire) begin
        done_q[cdb_tag] <= 1'b1;
        data_q[cdb_tag] <= cdb_data;
      end
      // Written last: the allocated slot is never busy beforehand, so it cannot collide with CDB.
      if (alloc_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        wb_q[tail_q]   <= alloc_wb;
        rd_q[tail_q]   <= alloc_rd;
        tail_q         <= tail_q + TAG_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid, alloc_wb, alloc_ready;
  logic [4:0]  alloc_rd;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [2:0]  qj_tag, qk_tag;
  logic        qj_rdy, qk_rdy;
  logic [31:0] qj_data, qk_data;
  logic        commit_valid, commit_wen;
  logic [4:0]  commit_idx;
  logic [31:0] commit_data;
  logic [2:0]  commit_tag;
  logic [3:0]  count;
  logic        flush_now;
`ifdef ROB_FLUSH_EN
  logic        flush;
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_wb(alloc_wb),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .qj_tag(qj_tag), .qj_rdy(qj_rdy), .qj_data(qj_data),
    .qk_tag(qk_tag), .qk_rdy(qk_rdy), .qk_data(qk_data),
    .commit_valid(commit_valid), .commit_wen(commit_wen), .commit_idx(commit_idx),
    .commit_data(commit_data), .commit_tag(commit_tag), .count(count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic        wb;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_next = 0;
  logic        m_cv = 1'b0, m_cw = 1'b0;
  logic [4:0]  m_ci = '0;
  logic [31:0] m_cd = '0;
  logic [2:0]  m_ct = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [2:0] t);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].tag == t) return i;
    return -1;
  endfunction

  task automatic chk_lookup(input string nm, input logic [2:0] t, input logic rdy,
                            input logic [31:0] d);
    int k;
    if (cdb_valid && cdb_tag == t) begin
      chk({nm, "_rdy"}, 32'(rdy), 32'd1);
      chk({nm, "_data"}, d, cdb_data);
    end else begin
      k = find(t);
      if (k < 0) begin
        chk({nm, "_rdy"}, 32'(rdy), 32'd0);
        chk({nm, "_data"}, d, 32'd0);
      end else begin
        chk({nm, "_rdy"}, 32'(rdy), 32'(mq[k].done));
        if (mq[k].done) chk({nm, "_data"}, d, mq[k].data);
      end
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < DEPTH));
    chk("alloc_tag", 32'(alloc_tag), 32'(m_next));
    chk("commit_valid", 32'(commit_valid), 32'(m_cv));
    chk("commit_wen", 32'(commit_wen), 32'(m_cw));
    chk("commit_idx", 32'(commit_idx), 32'(m_ci));
    chk("commit_data", commit_data, m_cd);
    chk("commit_tag", 32'(commit_tag), 32'(m_ct));
    chk_lookup("qj", qj_tag, qj_rdy, qj_data);
    chk_lookup("qk", qk_tag, qk_rdy, qk_data);
  endtask

  task automatic model_edge();
    bit   ret, room;
    int   k;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_next = 0;
      {m_cv, m_cw, m_ci, m_cd, m_ct} = '0;
    end else if (flush_now) begin
      mq.delete();
      m_next = 0;
      m_cv = 1'b0;
      m_cw = 1'b0;
    end else begin
      ret  = (mq.size() > 0) && mq[0].done;
      room = mq.size() < DEPTH;
      m_cv = ret;
      m_cw = ret && mq[0].wb;
      if (ret) begin
        m_ci = mq[0].rd;
        m_cd = mq[0].data;
        m_ct = mq[0].tag;
        void'(mq.pop_front());
      end
      if (cdb_valid) begin
        k = find(cdb_tag);
        if (k >= 0 && !mq[k].done) begin
          mq[k].done = 1'b1;
          mq[k].data = cdb_data;
        end
      end
      if (alloc_valid && room) begin
        e.tag  = 3'(m_next);
        e.rd   = alloc_rd;
        e.wb   = alloc_wb;
        e.done = 1'b0;
        e.data = '0;
        mq.push_back(e);
        m_next = (m_next + 1) % DEPTH;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst_n       = 1'b1;
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
`ifdef ROB_FLUSH_EN
    flush       = 1'b0;
`endif
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic wb);
    set_idle();
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    alloc_wb    = wb;
    cycle();
  endtask

  task automatic do_cdb(input logic [2:0] t, input logic [31:0] d);
    set_idle();
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    cycle();
  endtask

  task automatic do_idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    cycle();
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n    = 1'b0;
    alloc_rd = '0;
    alloc_wb = 1'b0;
    cdb_tag  = '0;
    cdb_data = '0;
    qj_tag   = 3'd0;
    qk_tag   = 3'd1;
    @(negedge clk);
    do_reset();

    // In-order retirement despite out-of-order completion.
    do_alloc(5'd1, 1'b1);
    do_alloc(5'd2, 1'b1);
    do_alloc(5'd3, 1'b1);
    do_cdb(3'd2, 32'h30);
    do_cdb(3'd0, 32'h10);
    do_cdb(3'd1, 32'h20);
    do_idle(5);

    // Fill, overflow attempt, then one retire reopens a slot.
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(5'(i + 8), 1'b1);
    #1 chk("full_ready", 32'(alloc_ready), 32'd0);
    do_alloc(5'd31, 1'b1);
    do_cdb(3'd0, 32'hABCD);
    do_idle(2);
    #1 chk("reopen_ready", 32'(alloc_ready), 32'd1);
    do_alloc(5'd4, 1'b1);
    do_idle(1);

    // Non-writeback instruction.
    do_reset();
    do_alloc(5'd7, 1'b0);
    do_cdb(3'd0, 32'h55);
    #1 chk("cdb_latency_t1", 32'(commit_valid), 32'd0);
    cycle();
    #1 chk("nowb_valid", 32'(commit_valid), 32'd1);
    chk("nowb_wen", 32'(commit_wen), 32'd0);
    chk("nowb_tag", 32'(commit_tag), 32'd0);
    do_idle(1);

    // Same-cycle bypass, then stored value on the next cycle.
    do_reset();
    for (int i = 0; i < 6; i++) do_alloc(5'(i), 1'b1);
    set_idle();
    qj_tag    = 3'd5;
    cdb_valid = 1'b1;
    cdb_tag   = 3'd5;
    cdb_data  = 32'hDEAD;
    #1 chk("bypass_rdy", 32'(qj_rdy), 32'd1);
    chk("bypass_data", qj_data, 32'hDEAD);
    cycle();
    set_idle();
    #1 chk("stored_rdy", 32'(qj_rdy), 32'd1);
    chk("stored_data", qj_data, 32'hDEAD);
    do_idle(1);

    // Twelve rounds exercise pointer wrap.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      do_alloc(5'(r), 1'b1);
      do_cdb(3'(r), 32'(r * 3 + 1));
    end
    do_idle(3);

    // Reset mid-operation, then a stale CDB is ignored.
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(5'(i), 1'b1);
    do_reset();
    #1 chk("rst_count", 32'(count), 32'd0);
    chk("rst_tag", 32'(alloc_tag), 32'd0);
    chk("rst_cv", 32'(commit_valid), 32'd0);
    do_cdb(3'd2, 32'h99);
    do_idle(2);

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 5; i++) do_alloc(5'(i), 1'b1);
    do_cdb(3'd0, 32'h11);
    set_idle();
    flush = 1'b1;
    cycle();
    do_cdb(3'd2, 32'h77);
    do_idle(2);
`endif

    // Random traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      set_idle();
      rst_n = ($urandom_range(0, 79) != 0);
`ifdef ROB_FLUSH_EN
      flush = ($urandom_range(0, 59) == 0);
`endif
      alloc_valid = 1'($urandom);
      alloc_rd    = 5'($urandom);
      alloc_wb    = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        cdb_valid = 1'b1;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          cdb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
        else
          cdb_tag = 3'($urandom);
        cdb_data = $urandom;
      end
      qj_tag = 3'($urandom);
      qk_tag = ($urandom_range(0, 1) != 0) ? cdb_tag : 3'($urandom);
      cycle();
    end
    do_idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
